// File: rtl/audio_i2s_dac_serializer.sv
// ---------------------------------------------------------------------------
// audio_i2s_dac_serializer
//
// Purpose:
//   Serialises the parallel 16-bit sample from the audio output PIO as an I2S
//   stereo stream for a WM8731 codec DAC running in slave mode. A fresh
//   sample pair is latched once per frame, and a one-clk frame_tick marks
//   that latch so software can pace its sample writes.
//
//   Frame layout is 32 BCLK slots. Slot 0 starts the left word (LRCK low).
//   Slot 16 starts the right word (LRCK high). Data lags LRCK by one BCLK,
//   so slot k (1..31) carries frame word bit 31-(k-1). Slot 0 carries the
//   previous frame's last bit (R[0]). LRCK and data change only on BCLK
//   falling edges, so the codec samples them on rising edges.
//
// Parameters:
//   BCLK_HALF : clk cycles per BCLK half-period (minimum 2)
//   MONO      : 1 = sample_left feeds both channels, 0 = independent channels
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   run enable (level); low acts as a synchronous clear
//   sample_left  in   [15:0] left / mono sample, two's complement
//   sample_right in   [15:0] right sample (ignored when MONO=1)
//   aud_bclk     out  bit clock to codec
//   aud_daclrck  out  word select: 0 = left, 1 = right
//   aud_dacdat   out  serial data, MSB first
//   frame_tick   out  one-clk pulse when a new sample pair is latched
// ---------------------------------------------------------------------------
module audio_i2s_dac_serializer #(
    parameter int BCLK_HALF = 16,
    parameter int MONO      = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        frame_tick
);

    // Divider width: at least one bit, even for the minimum BCLK_HALF of 2.
    localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             bclk_r;
    logic             lrck_r;
    logic             dat_r;
    logic             tick_r;
    logic [4:0]       slot_r;
    logic [31:0]      sh_r;

    logic             terminal_s;
    logic             fall_s;
    logic [4:0]       slot_next_s;
    logic [31:0]      frame_word_s;

    // Builds the 32-bit frame word {left, right}; mono duplicates the left.
    function automatic logic [31:0] frame_word(input logic [15:0] left,
                                               input logic [15:0] right);
        logic [31:0] word;
        if (MONO != 0) begin
            word = {left, left};
        end else begin
            word = {left, right};
        end
        return word;
    endfunction

    // Divider terminal count, falling-edge event and next slot number.
    always_comb begin
        terminal_s   = (div_cnt_r == DIV_LAST);
        // A terminal count while BCLK is high is the BCLK falling edge.
        fall_s       = terminal_s & bclk_r;
        // 5-bit increment wraps 31 -> 0 naturally.
        slot_next_s  = slot_r + 5'd1;
        frame_word_s = frame_word(sample_left, sample_right);
    end

    // BCLK divider, slot sequencing, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
            dat_r     <= 1'b0;
            tick_r    <= 1'b0;
            slot_r    <= 5'd31;
            sh_r      <= 32'h0000_0000;
        end else if (!enable) begin
            // Clean stop: the next enable begins a fresh frame whose first
            // slot 0 carries a zero bit before the newly latched word.
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
            dat_r     <= 1'b0;
            tick_r    <= 1'b0;
            slot_r    <= 5'd31;
            sh_r      <= 32'h0000_0000;
        end else begin
            tick_r <= 1'b0;

            if (terminal_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                bclk_r    <= ~bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end

            if (fall_s) begin
                slot_r <= slot_next_s;
                lrck_r <= slot_next_s[4];
                // The bit shifted out here was loaded one slot earlier,
                // which produces the one-BCLK I2S data delay.
                dat_r  <= sh_r[31];
                if (slot_next_s == 5'd0) begin
                    sh_r   <= frame_word_s;
                    tick_r <= 1'b1;
                end else begin
                    sh_r   <= {sh_r[30:0], 1'b0};
                end
            end else begin
                slot_r <= slot_r;
                sh_r   <= sh_r;
            end
        end
    end

    assign aud_bclk    = bclk_r;
    assign aud_daclrck = lrck_r;
    assign aud_dacdat  = dat_r;
    assign frame_tick  = tick_r;

endmodule

// File: tb/tb_audio_i2s_dac_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for audio_i2s_dac_serializer. A mono (MONO=1) and a stereo
// (MONO=0) instance share clock, reset, enable and sample inputs.
// A reference model, driven by the count of clk edges since the last clean
// start, predicts every output on every cycle. Table vectors and
// hand-written sequences cover frame content, latch timing, enable drop
// and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_audio_i2s_dac_serializer;

    localparam int BH    = 4;
    localparam int FRAME = 64 * BH;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] sample_left;
    logic [15:0] sample_right;

    logic bclk_m, lrck_m, dat_m, tick_m;
    logic bclk_s, lrck_s, dat_s, tick_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_i2s_dac_serializer #(.BCLK_HALF(BH), .MONO(1)) u_mono (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sample_left(sample_left), .sample_right(sample_right),
        .aud_bclk(bclk_m), .aud_daclrck(lrck_m),
        .aud_dacdat(dat_m), .frame_tick(tick_m)
    );

    audio_i2s_dac_serializer #(.BCLK_HALF(BH), .MONO(0)) u_st (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sample_left(sample_left), .sample_right(sample_right),
        .aud_bclk(bclk_s), .aud_daclrck(lrck_s),
        .aud_dacdat(dat_s), .frame_tick(tick_s)
    );

    // ---------------- reference model ----------------
    int          t;          // clk edges since last clean start
    bit          m_have;     // a word has been latched since the clean start
    logic [31:0] m_word [2]; // word currently being sent, per instance
    logic [3:0]  m_exp  [2]; // expected {bclk, lrck, dat, tick}
    bit          m_fall;
    bit          m_tick;
    int          m_slot;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] w_mono;
        logic [31:0] w_st;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [31:0] word_for(input int inst);
        logic [31:0] w;
        if (inst == 0) w = {sample_left, sample_left};
        else           w = {sample_left, sample_right};
        return w;
    endfunction

    function automatic logic [3:0] dut_out(input int inst);
        logic [3:0] v;
        if (inst == 0) v = {bclk_m, lrck_m, dat_m, tick_m};
        else           v = {bclk_s, lrck_s, dat_s, tick_s};
        return v;
    endfunction

    task automatic model_clear();
        t = 0;
        m_have = 1'b0;
        m_fall = 1'b0;
        m_tick = 1'b0;
        m_slot = 31;
        for (int i = 0; i < 2; i++) begin
            m_exp[i]  = 4'h0;
            m_word[i] = 32'h0;
        end
    endtask

    // Called just after each posedge, with the inputs the DUT sampled.
    task automatic model_edge();
        int n;
        if (!reset_n || !enable) begin
            model_clear();
            return;
        end
        t = t + 1;
        m_fall = 1'b0;
        m_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_exp[i][3] = ((t / BH) % 2) == 1;
            m_exp[i][0] = 1'b0;
        end
        if ((t % (2 * BH)) == 0) begin
            n = t / (2 * BH);
            m_slot = (n - 1) % 32;
            m_fall = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_exp[i][2] = (m_slot >= 16);
                if (m_slot == 0) begin
                    m_exp[i][1] = m_have ? m_word[i][0] : 1'b0;
                    m_word[i]   = word_for(i);
                    m_exp[i][0] = 1'b1;
                end else begin
                    m_exp[i][1] = m_word[i][31 - (m_slot - 1)];
                end
            end
            if (m_slot == 0) begin
                m_have = 1'b1;
                m_tick = 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("mono_outputs", {28'h0, dut_out(0)}, {28'h0, m_exp[0]});
        chk("stereo_outputs", {28'h0, dut_out(1)}, {28'h0, m_exp[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            step();
            k++;
        end while (!m_tick && k < 2 * FRAME);
        chk("tick_timeout", {31'h0, m_tick}, 32'h1);
    endtask

    task automatic wait_fall();
        int k = 0;
        do begin
            step();
            k++;
        end while (!m_fall && k <= 2 * BH);
        chk("fall_timeout", {31'h0, m_fall}, 32'h1);
    endtask

    // Collects slots 1..31 plus the next slot 0, starting right after a tick.
    task automatic capture(output logic [31:0] w0, output logic [31:0] w1,
                           input int chg_slot, input logic [15:0] chg_val);
        w0 = 32'h0;
        w1 = 32'h0;
        for (int f = 0; f < 32; f++) begin
            wait_fall();
            w0 = {w0[30:0], dat_m};
            w1 = {w1[30:0], dat_s};
            if (m_slot == chg_slot) sample_left = chg_val;
        end
    endtask

    // Measures first BCLK rise, first tick and tick period from a clean start.
    task automatic count_startup(input string tag);
        int e = 0;
        int rise = 0;
        int tk = 0;
        while (tk == 0 && e < 40) begin
            step();
            e++;
            if (rise == 0 && bclk_m) rise = e;
            if (tick_m) tk = e;
        end
        chk({tag, "_first_rise"}, rise, BH);
        chk({tag, "_first_tick"}, tk, 2 * BH);
        e = 0;
        do begin
            step();
            e++;
        end while (!tick_m && e < 2 * FRAME);
        chk({tag, "_tick_period"}, e, FRAME);
    endtask

    // Global time limit in case a wait construct is broken.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w0, w1;
        int k;

        tbl[0] = '{16'hA5C3, 16'h1234, 32'hA5C3A5C3, 32'hA5C31234};
        tbl[1] = '{16'h8000, 16'h0001, 32'h80008000, 32'h80000001};
        tbl[2] = '{16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'hFFFF0000};
        tbl[3] = '{16'h0000, 16'hFFFF, 32'h00000000, 32'h0000FFFF};
        tbl[4] = '{16'h1357, 16'h9BDF, 32'h13571357, 32'h13579BDF};

        // Reset with enable held high: outputs stay 0, then startup timing.
        reset_n      = 1'b0;
        enable       = 1'b1;
        sample_left  = 16'h0000;
        sample_right = 16'h0000;
        model_clear();
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b1;
        count_startup("reset");

        // Table vectors: latch at a tick, then capture the whole frame.
        for (int v = 0; v < 5; v++) begin
            sample_left  = tbl[v].l;
            sample_right = tbl[v].r;
            wait_tick();
            capture(w0, w1, -1, 16'h0000);
            chk($sformatf("tbl%0d_mono", v), w0, tbl[v].w_mono);
            chk($sformatf("tbl%0d_stereo", v), w1, tbl[v].w_st);
        end

        // Sample change at slot 10 is invisible until the next frame.
        sample_left  = 16'h1234;
        sample_right = 16'h0000;
        wait_tick();
        capture(w0, w1, 10, 16'hFFFF);
        chk("late_chg_mono_cur", w0, 32'h12341234);
        chk("late_chg_st_cur", w1, 32'h12340000);
        capture(w0, w1, -1, 16'h0000);
        chk("late_chg_mono_next", w0, 32'hFFFFFFFF);
        chk("late_chg_st_next", w1, 32'hFFFF0000);

        // Drop enable at slot 20, then restart a clean frame.
        wait_tick();
        for (int f = 0; f < 20; f++) wait_fall();
        chk("drop_slot", m_slot, 20);
        enable = 1'b0;
        step();
        chk("drop_mono_zero", {28'h0, dut_out(0)}, 32'h0);
        chk("drop_st_zero", {28'h0, dut_out(1)}, 32'h0);
        for (int i = 0; i < 3 * BH; i++) step();
        enable       = 1'b1;
        sample_left  = 16'h7E81;
        sample_right = 16'h0F0F;
        k = 0;
        do begin
            step();
            k++;
        end while (!tick_m && k < 40);
        chk("reenable_tick_latency", k, 2 * BH);
        capture(w0, w1, -1, 16'h0000);
        chk("reenable_mono_word", w0, 32'h7E817E81);
        chk("reenable_st_word", w1, 32'h7E810F0F);

        // Asynchronous reset while BCLK is high.
        k = 0;
        do begin
            step();
            k++;
        end while (!bclk_m && k < 4 * BH);
        chk("bclk_high_before_reset", {31'h0, bclk_m}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("async_rst_mono", {28'h0, dut_out(0)}, 32'h0);
        chk("async_rst_st", {28'h0, dut_out(1)}, 32'h0);
        @(negedge clk);
        step();
        step();
        reset_n = 1'b1;
        count_startup("async");

        // Randomised run: random samples and random enable drops.
        for (int i = 0; i < 6000; i++) begin
            step();
            if ($urandom_range(0, 39) == 0) begin
                sample_left  = 16'($urandom);
                sample_right = 16'($urandom);
            end
            if (enable) begin
                if ($urandom_range(0, 599) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                enable = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_i2s_dac_serializer.md
Name: audio_i2s_dac_serializer

Overview:
- Downstream stage of the NIOS audio output PIO.
- Takes the parallel 16-bit sample presented on the PIO's output port and serialises it as I2S stereo (BCLK, DACLRCK, DACDAT) to the board's WM8731 codec DAC, which runs in slave mode.
- Latches a fresh sample once per frame.
- Emits a one-cycle frame_tick that software polls or uses as an interrupt to pace sample writes.

Parameters:
- BCLK_HALF, 16: clk cycles per BCLK half-period. Minimum 2. At 50 MHz the default gives BCLK 1.5625 MHz and a frame rate of 48.828 kHz.
- MONO, 1: 1 = sample_left drives both channels and sample_right is ignored. 0 = independent channels.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  serializer run enable, level.
- sample_left  in  16  left or mono sample, two's complement, connected to the audio PIO out_port.
- sample_right  in  16  right sample; unused when MONO=1.
- aud_bclk  out  1  bit clock to codec.
- aud_daclrck  out  1  word select: 0 = left, 1 = right.
- aud_dacdat  out  1  serial data, MSB first.
- frame_tick  out  1  one-clk pulse at each frame start (sample latch).

Behaviour:
- Reset (async assert, sync release): all outputs 0; div_cnt=0; slot=31; shift register sh[31:0]=0.
- Internal state:
  - div_cnt counts 0..BCLK_HALF-1.
  - At terminal count, bclk_r toggles and div_cnt wraps to 0.
  - "Fall event" = terminal count while bclk_r=1. "Rise event" = terminal count while bclk_r=0.
- On each fall event, slot advances modulo 32 (31 wraps to 0). aud_daclrck <= new_slot[4] and aud_dacdat <= sh[31], all in the same clk.
  - New slot = 0: sh <= {L,R}, where L=sample_left and R = (MONO ? sample_left : sample_right) sampled that clk. frame_tick=1 for that clk only.
  - New slot 1..31: sh <= sh<<1.
- Resulting I2S timing:
  - MSB is delayed one BCLK after the LRCK edge. Slot k (1..31) carries word bit 31-(k-1). Slot 0 carries the previous frame's R[0].
  - Data and LRCK change only on BCLK falling edges, so the codec samples on rising edges.
- Rise events change only aud_bclk.
- First frame after reset or enable carries: slot 0 = 0, then the latched sample.
- Frame period is 64*BCLK_HALF clk cycles. Latch latency: sample_left is captured on the fall-event edge into slot 0; changes at any other time are not visible until the next frame.
- enable=0 acts as a synchronous clear on the next clk edge: div_cnt=0, bclk/lrck/dacdat/frame_tick=0, slot=31, sh=0.
  - Deasserting enable mid-frame truncates the frame immediately.
  - Reasserting starts a clean frame: the first rise event after BCLK_HALF cycles, the first fall event into slot 0 after 2*BCLK_HALF cycles.
- reset_n asserted mid-frame clears everything asynchronously. After release, behaviour matches the enable-restart case.
- frame_tick never asserts while enable=0 or during reset.
- No arithmetic on sample data; bits pass through unchanged.

Test Plan:
- Reset with enable=1 held: during reset all outputs 0. After release with BCLK_HALF=4: first aud_bclk rise at clk 4, first fall plus frame_tick at clk 8, then frame_tick every 256 clk.
- MONO=1, sample_left=16'hA5C3: over slots 1..16 aud_dacdat = 1010_0101_1100_0011. Slots 17..31 plus next slot 0 repeat the same pattern. aud_daclrck=0 for slots 0..15 and 1 for slots 16..31.
- MONO=0, sample_left=16'h8000, sample_right=16'h0001: dacdat=1 only in slot 1 and in the following frame's slot 0; 0 elsewhere.
- Change sample_left from 16'h1234 to 16'hFFFF at slot 10: current frame still serialises 16'h1234. Next frame serialises 16'hFFFF.
- Drop enable at slot 20: next clk all outputs 0 and frame_tick stays 0. Re-enable: frame_tick after 2*BCLK_HALF clk, with the current sample latched.
- Assert reset_n=0 asynchronously mid-BCLK-high: outputs go 0 without a clk edge. Recovery timing matches the first scenario.
